// File: rtl/pid_pkg.sv
// pid_pkg: FSM encoding, default widths and the signed clamp helper
// shared by the pid_ctrl_param datapath and its MAC.
package pid_pkg;

   typedef enum logic [2:0] {
      IDLE, LATCH, ERR, MP, MI, MD, SUM
   } state_t;

   localparam int DW_D       = 9;
   localparam int KW_D       = 8;
   localparam int FRAC_D     = 4;
   localparam int IW_D       = 16;
   localparam int OW_D       = 18;
   localparam int PRESCALE_D = 1000;
   localparam int EW_D       = DW_D + 1;
   localparam int ACCW_D     = KW_D + IW_D + 2;

   function automatic logic signed [63:0] sat_signed(
      input logic signed [63:0] v,
      input logic signed [63:0] lo,
      input logic signed [63:0] hi
   );
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/pid_ctrl_param_mac.sv
// pid_mac: registered signed multiply-accumulate, one product per cycle.
// clr with en restarts the sum from the current product.
module pid_mac
   import pid_pkg::*;
#(
   parameter int KW   = KW_D,
   parameter int IW   = IW_D,
   parameter int ACCW = ACCW_D
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic signed [KW-1:0]   a,
   input  logic signed [IW-1:0]   b,
   output logic signed [ACCW-1:0] acc
);

   logic signed [KW+IW-1:0] prod;

   assign prod = (KW+IW)'(a) * (KW+IW)'(b);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= (clr ? '0 : acc) + ACCW'(prod);
      end else if (clr) begin
         acc <= '0;
      end
   end

endmodule

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: prescaled discrete PID, one shared MAC, 6-cycle sample FSM.
// Define ANTIWINDUP_EN for conditional integration while the output clamps.
module pid_ctrl_param
   import pid_pkg::*;
#(
   parameter int DW       = DW_D,
   parameter int KW       = KW_D,
   parameter int FRAC     = FRAC_D,
   parameter int IW       = IW_D,
   parameter int OW       = OW_D,
   parameter int PRESCALE = PRESCALE_D
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] yactual,
   input  logic signed [DW-1:0] referencia,
   input  logic signed [KW-1:0] kp,
   input  logic signed [KW-1:0] ki,
   input  logic signed [KW-1:0] kd,
   output logic                 ena2,
   output logic signed [OW-1:0] PWMin,
   output logic                 out_vld,
   output logic                 sat,
   output logic                 overrun
);

   localparam int EW   = DW + 1;
   localparam int DFW  = DW + 2;
   localparam int ACCW = KW + IW + 2;
   localparam int CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic signed [63:0] IMAX = (64'sd1 <<< (IW-1)) - 64'sd1;
   localparam logic signed [63:0] OMAX = (64'sd1 <<< (OW-1)) - 64'sd1;
   localparam logic signed [63:0] OMIN = -(64'sd1 <<< (OW-1));

   logic [CW-1:0]          cnt;
   state_t                 state, nxt;
   logic signed [DW-1:0]   y_r, r_r;
   logic signed [KW-1:0]   kp_r, ki_r, kd_r;
   logic signed [EW-1:0]   e_r, ep_r, e_c;
   logic signed [DFW-1:0]  d_r, d_c;
   logic signed [IW-1:0]   i_r, inext_r, inext_c;
   logic signed [IW:0]     isum;
   logic signed [ACCW-1:0] acc, u_c;
   logic signed [KW-1:0]   mac_a;
   logic signed [IW-1:0]   mac_b;
   logic                   mac_clr, mac_en;
   logic                   sat_c, hold_i;

   assign ena2 = (cnt == CW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      cnt <= '0;
      else if (ena2) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (ena2) nxt = LATCH;
         LATCH:   nxt = ERR;
         ERR:     nxt = MP;
         MP:      nxt = MI;
         MI:      nxt = MD;
         MD:      nxt = SUM;
         SUM:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      mac_a   = kp_r;
      mac_b   = IW'(e_r);
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      unique case (state)
         MP: begin
            mac_clr = 1'b1;
            mac_en  = 1'b1;
         end
         MI: begin
            mac_a  = ki_r;
            mac_b  = inext_r;
            mac_en = 1'b1;
         end
         MD: begin
            mac_a  = kd_r;
            mac_b  = IW'(d_r);
            mac_en = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      e_c     = EW'(r_r) - EW'(y_r);
      d_c     = DFW'(e_c) - DFW'(ep_r);
      isum    = (IW+1)'(i_r) + (IW+1)'(e_c);
      inext_c = IW'(sat_signed(64'(isum), -IMAX, IMAX));
      u_c     = acc >>> FRAC;
      sat_c   = (sat_signed(64'(u_c), OMIN, OMAX) != 64'(u_c));
`ifdef ANTIWINDUP_EN
      // freeze I only while clamped and the error pushes further into the clamp
      hold_i  = sat_c && (e_r[EW-1] == u_c[ACCW-1]);
`else
      hold_i  = 1'b0;
`endif
   end

   pid_mac #(
      .KW   (KW),
      .IW   (IW),
      .ACCW (ACCW)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (mac_a),
      .b   (mac_b),
      .acc (acc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         y_r     <= '0;
         r_r     <= '0;
         kp_r    <= '0;
         ki_r    <= '0;
         kd_r    <= '0;
         e_r     <= '0;
         ep_r    <= '0;
         d_r     <= '0;
         i_r     <= '0;
         inext_r <= '0;
         PWMin   <= '0;
         out_vld <= 1'b0;
         sat     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= nxt;
         out_vld <= 1'b0;
         if (ena2 && state != IDLE) overrun <= 1'b1;
         if (state == LATCH) begin
            y_r  <= yactual;
            r_r  <= referencia;
            kp_r <= kp;
            ki_r <= ki;
            kd_r <= kd;
         end
         if (state == ERR) begin
            e_r     <= e_c;
            d_r     <= d_c;
            inext_r <= inext_c;
         end
         if (state == SUM) begin
            PWMin   <= OW'(sat_signed(64'(u_c), OMIN, OMAX));
            sat     <= sat_c;
            out_vld <= 1'b1;
            ep_r    <= e_r;
            if (!hold_i) i_r <= inext_r;
         end
      end
   end

endmodule
